issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 47 ++++
 rtl/issue_buf.sv | 71 +++++++
 rtl/issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared constants and types for the issue controller.
// Contents: data/opcode widths, buffer sizing, RV32 opcode constants, the
// fetch-entry payload struct and the head-instruction classifier.
package issue_ctrl_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned OPCODE_WIDTH = 7;
  localparam int unsigned BUF_DEPTH    = 2;
  localparam int unsigned CNT_WIDTH    = 2;
  localparam int unsigned PERF_WIDTH   = 32;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = 7'b0110011;

  // One buffered fetch: instruction word plus its PC.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    UNIT_RS  = 2'd0,
    UNIT_LSB = 2'd1,
    UNIT_ILL = 2'd2
  } unit_e;

  // Map an opcode to the execution unit that must have room for it.
  function automatic unit_e classify(input logic [OPCODE_WIDTH-1:0] opcode);
    unit_e unit;
    unit = UNIT_ILL;
    case (opcode)
      OPC_LOAD, OPC_STORE: unit = UNIT_LSB;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_OPIMM, OPC_OP: unit = UNIT_RS;
      default: unit = UNIT_ILL;
    endcase
    return unit;
  endfunction

endpackage

// File: rtl/issue_buf.sv
// Two-entry instruction FIFO between fetch and issue.
// Ports: clk, rst_n (async active-low); push_i/entry_i write at the tail;
// pop_i retires the head; flush_i empties the buffer (wins over push/pop);
// head_o/head_valid_o expose the oldest entry; count_o is the occupancy.
module issue_buf
  import issue_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  fetch_entry_t         entry_i,
  output fetch_entry_t         head_o,
  output logic                 head_valid_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  fetch_entry_t         mem_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] valid_q;
  // Single-bit pointers: inverting one wraps it across the two slots.
  logic                 head_q;
  logic                 tail_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // Storage and pointers. Head and tail only coincide when the buffer is
  // empty (no pop) or full (no push), so the two valid_q writes never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q]   <= entry_i;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ~tail_q;
      end
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ~head_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o       = mem_q[head_q];
  assign head_valid_o = valid_q[head_q];
  assign count_o      = count_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: buffers fetched instructions in issue_buf and
// hands the head to decode when the ROB and the target unit (RS or LSB)
// have room. Illegal opcodes are dropped without a ROB allocation.
// Ports: clk, rst (async active-low), rdy (global enable);
//   in_fetch_valid/in_fetch_instr/in_fetch_pc + out_fetch_ready: fetch handshake;
//   in_rob_full/in_rs_full/in_lsb_full: back-pressure; in_rollback: flush;
//   out_dec_instr/out_dec_pc/out_rob_alloc: issue to decode; out_stall.
// Optional macro ISSUE_PERF_CNT_EN adds out_perf_issued and out_perf_stall.
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_fetch_valid,
  input  logic [DATA_WIDTH-1:0] in_fetch_instr,
  input  logic [DATA_WIDTH-1:0] in_fetch_pc,
  output logic                  out_fetch_ready,
  input  logic                  in_rob_full,
  input  logic                  in_rs_full,
  input  logic                  in_lsb_full,
  input  logic                  in_rollback,
  output logic [DATA_WIDTH-1:0] out_dec_instr,
  output logic [DATA_WIDTH-1:0] out_dec_pc,
  output logic                  out_rob_alloc,
  output logic                  out_stall
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0] out_perf_issued,
  output logic [PERF_WIDTH-1:0] out_perf_stall
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e               state_q;
  state_e               state_d;
  fetch_entry_t         head;
  fetch_entry_t         fetch_entry;
  logic                 head_valid;
  logic [CNT_WIDTH-1:0] count;
  unit_e                head_unit;
  logic                 unit_full;
  logic                 head_legal;
  logic                 active;
  logic                 blocked;
  logic                 issue;
  logic                 pop;
  logic                 push;
  logic                 flush;

  assign fetch_entry = '{instr: in_fetch_instr, pc: in_fetch_pc};

  issue_buf u_buf (
    .clk          (clk),
    .rst_n        (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (flush),
    .entry_i      (fetch_entry),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (count)
  );

  // Head classification and issue decision.
  always_comb begin
    head_unit  = classify(head.instr[OPCODE_WIDTH-1:0]);
    head_legal = (head_unit != UNIT_ILL);
    unit_full  = (head_unit == UNIT_LSB) ? in_lsb_full : in_rs_full;
    // Reset gating keeps every output quiet while rst is held low.
    active     = rst && rdy && !in_rollback;
    blocked    = head_valid && head_legal && (in_rob_full || unit_full);
    issue      = active && head_valid && head_legal && !in_rob_full && !unit_full;
    // Illegal heads leave the buffer regardless of back-pressure.
    pop        = issue || (active && head_valid && !head_legal);
    out_fetch_ready = active && (count < CNT_WIDTH'(BUF_DEPTH)) && (state_q == ST_RUN);
    push       = in_fetch_valid && out_fetch_ready;
    flush      = rdy && in_rollback;
  end

  // Decode-facing outputs: a NOP whenever nothing is issued.
  always_comb begin
    out_rob_alloc = issue;
    out_dec_instr = issue ? head.instr : '0;
    out_dec_pc    = issue ? head.pc : '0;
  end

  // Next-state logic; rdy low freezes the FSM.
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (in_rollback) begin
        state_d = ST_FLUSH;
      end else if (state_q == ST_FLUSH) begin
        state_d = ST_RUN;
      end else if (blocked) begin
        state_d = ST_STALL;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_stall = (state_q == ST_STALL);

`ifdef ISSUE_PERF_CNT_EN
  logic [PERF_WIDTH-1:0] perf_issued_q;
  logic [PERF_WIDTH-1:0] perf_stall_q;

  // Free-running event counters, wrapping naturally at full width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else if (rdy) begin
      if (issue) begin
        perf_issued_q <= perf_issued_q + PERF_WIDTH'(1);
      end
      if (state_q == ST_STALL) begin
        perf_stall_q <= perf_stall_q + PERF_WIDTH'(1);
      end
    end
  end

  assign out_perf_issued = perf_issued_q;
  assign out_perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed cycle table, mid-operation reset, then
// randomized traffic checked against a queue-based reference model.
module tb_issue_ctrl;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] ADD  = 32'h002081b3;
  localparam logic [31:0] LW   = 32'h0000a203;
  localparam logic [31:0] SW   = 32'h0020a023;
  localparam logic [31:0] LUI  = 32'h000122b7;
  localparam logic [31:0] ILL  = 32'h0000007f;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        in_fetch_valid;
  logic [31:0] in_fetch_instr;
  logic [31:0] in_fetch_pc;
  logic        out_fetch_ready;
  logic        in_rob_full;
  logic        in_rs_full;
  logic        in_lsb_full;
  logic        in_rollback;
  logic [31:0] out_dec_instr;
  logic [31:0] out_dec_pc;
  logic        out_rob_alloc;
  logic        out_stall;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] out_perf_issued;
  logic [31:0] out_perf_stall;
`endif

  issue_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .in_fetch_valid  (in_fetch_valid),
    .in_fetch_instr  (in_fetch_instr),
    .in_fetch_pc     (in_fetch_pc),
    .out_fetch_ready (out_fetch_ready),
    .in_rob_full     (in_rob_full),
    .in_rs_full      (in_rs_full),
    .in_lsb_full     (in_lsb_full),
    .in_rollback     (in_rollback),
    .out_dec_instr   (out_dec_instr),
    .out_dec_pc      (out_dec_pc),
    .out_rob_alloc   (out_rob_alloc),
    .out_stall       (out_stall)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .out_perf_issued (out_perf_issued),
    .out_perf_stall  (out_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        rdy, fv;
    logic [31:0] instr, pc;
    logic        rob, rs, lsb, rb;
    logic        e_ready, e_alloc;
    logic [31:0] e_instr, e_pc;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic r, fv, input logic [31:0] ins, p,
                            input logic rob, rs, lsb, rb,
                            input logic er, ea, input logic [31:0] ei, ep, input logic es);
    vec_t t;
    t.rdy = r; t.fv = fv; t.instr = ins; t.pc = p;
    t.rob = rob; t.rs = rs; t.lsb = lsb; t.rb = rb;
    t.e_ready = er; t.e_alloc = ea; t.e_instr = ei; t.e_pc = ep; t.e_stall = es;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic r, fv, input logic [31:0] ins, p,
                       input logic rob, rs, lsb, rb);
    rdy = r; in_fetch_valid = fv; in_fetch_instr = ins; in_fetch_pc = p;
    in_rob_full = rob; in_rs_full = rs; in_lsb_full = lsb; in_rollback = rb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef enum { M_RUN, M_STALL, M_FLUSH } mstate_e;
  typedef enum { K_RS, K_LSB, K_ILL } kind_e;

  ent_t        mq[$];
  mstate_e     mst;
  logic [31:0] m_issued;
  logic [31:0] m_stalls;

  function automatic kind_e kind_of(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op inside {7'h03, 7'h23}) return K_LSB;
    if (op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33}) return K_RS;
    return K_ILL;
  endfunction

  logic [6:0] op_pool [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    op_pool[0] = 7'h03; op_pool[1] = 7'h23; op_pool[2] = 7'h37; op_pool[3] = 7'h17;
    op_pool[4] = 7'h6f; op_pool[5] = 7'h67; op_pool[6] = 7'h63; op_pool[7] = 7'h13;
    op_pool[8] = 7'h33; op_pool[9] = 7'h7f;

    //  rdy fv instr pc      rob rs lsb rb | ready alloc instr pc    stall
    v(1, 1, ADDI, 32'h00, 0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 1, ADDI, 32'h00, 0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, ADD,  32'h04, 0, 1, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, LW,   32'h08, 0, 1, 0, 0,   1, 0, 0,    0,     0);
    v(1, 0, 0,    0,      0, 1, 0, 0,   0, 0, 0,    0,     1);
    v(1, 0, 0,    0,      0, 1, 0, 0,   0, 0, 0,    0,     1);
    v(1, 0, 0,    0,      0, 0, 0, 0,   0, 1, ADD,  32'h04, 1);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 1, LW,   32'h08, 0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, SW,   32'h10, 1, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, LUI,  32'h14, 1, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, ADDI, 32'h18, 1, 0, 0, 0,   0, 0, 0,    0,     1);
    v(1, 1, ADDI, 32'h18, 0, 0, 0, 0,   0, 1, SW,   32'h10, 1);
    v(1, 1, ADDI, 32'h18, 0, 0, 0, 0,   1, 1, LUI,  32'h14, 0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 1, ADDI, 32'h18, 0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, ADD,  32'h20, 1, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, LW,   32'h24, 1, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 0, 0,    0,      1, 0, 0, 1,   0, 0, 0,    0,     1);
    v(1, 1, ADDI, 32'h30, 0, 0, 0, 0,   0, 0, 0,    0,     0);
    v(1, 1, ADDI, 32'h30, 0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 1, ADDI, 32'h30, 0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, ILL,  32'h40, 0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 1, ADDI, 32'h44, 0, 0, 0, 0,   1, 0, 0,    0,     0);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 1, ADDI, 32'h44, 0);
    v(1, 1, ADD,  32'h50, 0, 1, 0, 0,   1, 0, 0,    0,     0);
    v(1, 0, 0,    0,      0, 1, 0, 0,   1, 0, 0,    0,     0);
    v(0, 0, 0,    0,      0, 1, 0, 0,   0, 0, 0,    0,     1);
    v(0, 0, 0,    0,      0, 0, 0, 0,   0, 0, 0,    0,     1);
    v(0, 1, ADDI, 32'h54, 0, 0, 0, 0,   0, 0, 0,    0,     1);
    v(1, 0, 0,    0,      0, 0, 0, 0,   0, 1, ADD,  32'h50, 1);
    v(1, 0, 0,    0,      0, 0, 0, 0,   1, 0, 0,    0,     0);

    // Reset: outputs quiet even with a fetch offered and rdy high.
    rst = 1'b0;
    drive(1, 1, ADDI, 32'h0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    chk("rst_ready", 0, 32'(out_fetch_ready), 0);
    chk("rst_alloc", 0, 32'(out_rob_alloc), 0);
    chk("rst_instr", 0, out_dec_instr, 0);
    chk("rst_pc",    0, out_dec_pc, 0);
    chk("rst_stall", 0, 32'(out_stall), 0);
`ifdef ISSUE_PERF_CNT_EN
    chk("rst_perf_issued", 0, out_perf_issued, 0);
    chk("rst_perf_stall",  0, out_perf_stall, 0);
`endif
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].fv, vecs[i].instr, vecs[i].pc,
            vecs[i].rob, vecs[i].rs, vecs[i].lsb, vecs[i].rb);
      #1;
      chk("vec_ready", i, 32'(out_fetch_ready), 32'(vecs[i].e_ready));
      chk("vec_alloc", i, 32'(out_rob_alloc),   32'(vecs[i].e_alloc));
      chk("vec_instr", i, out_dec_instr,        vecs[i].e_instr);
      chk("vec_pc",    i, out_dec_pc,           vecs[i].e_pc);
      chk("vec_stall", i, 32'(out_stall),       32'(vecs[i].e_stall));
      next_cycle();
    end

    // Reset mid-stall with two buffered entries: nothing may survive.
    drive(1, 1, ADD, 32'h60, 0, 1, 0, 0);
    next_cycle();
    drive(1, 1, LW, 32'h64, 0, 1, 0, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_stall", 0, 32'(out_stall), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_alloc", 0, 32'(out_rob_alloc), 0);
    chk("mid_rst_instr", 0, out_dec_instr, 0);
    chk("mid_rst_stall", 0, 32'(out_stall), 0);
    chk("mid_rst_ready", 0, 32'(out_fetch_ready), 0);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("post_rst_alloc", 0, 32'(out_rob_alloc), 0);
    chk("post_rst_ready", 0, 32'(out_fetch_ready), 1);
    next_cycle();
    chk("post_rst_alloc", 1, 32'(out_rob_alloc), 0);
    chk("post_rst_stall", 1, 32'(out_stall), 0);

    // Randomized traffic against the model, starting from the reset state.
    mq.delete();
    mst = M_RUN;
    m_issued = 0;
    m_stalls = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r, fv, rob, rs, lsb, rb;
      logic [31:0] ins, p;
      logic        e_ready, e_alloc, e_stall, do_pop, blk, busy;
      logic [31:0] e_instr, e_pc;
      kind_e       k;

      r   = ($urandom_range(0, 9) != 0);
      fv  = ($urandom_range(0, 9) < 6);
      ins = $urandom();
      ins[6:0] = op_pool[$urandom_range(0, 9)];
      p   = $urandom() & 32'hffff_fffc;
      rob = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 3) == 0);
      lsb = ($urandom_range(0, 3) == 0);
      rb  = r && ($urandom_range(0, 19) == 0);
      drive(r, fv, ins, p, rob, rs, lsb, rb);
      #1;

      e_ready = r && !rb && (mst == M_RUN) && (mq.size() < 2);
      e_alloc = 1'b0; e_instr = 0; e_pc = 0; do_pop = 1'b0; blk = 1'b0;
      if (mq.size() > 0) begin
        k    = kind_of(mq[0].instr);
        busy = rob || ((k == K_LSB) ? lsb : rs);
        blk  = (k != K_ILL) && busy;
        if (r && !rb) begin
          if (k == K_ILL) begin
            do_pop = 1'b1;
          end else if (!busy) begin
            do_pop = 1'b1; e_alloc = 1'b1; e_instr = mq[0].instr; e_pc = mq[0].pc;
          end
        end
      end
      e_stall = (mst == M_STALL);

      chk("rnd_ready", cyc, 32'(out_fetch_ready), 32'(e_ready));
      chk("rnd_alloc", cyc, 32'(out_rob_alloc),   32'(e_alloc));
      chk("rnd_instr", cyc, out_dec_instr,        e_instr);
      chk("rnd_pc",    cyc, out_dec_pc,           e_pc);
      chk("rnd_stall", cyc, 32'(out_stall),       32'(e_stall));
`ifdef ISSUE_PERF_CNT_EN
      chk("rnd_perf_issued", cyc, out_perf_issued, m_issued);
      chk("rnd_perf_stall",  cyc, out_perf_stall,  m_stalls);
`endif

      @(posedge clk);
      if (r) begin
        if (mst == M_STALL) m_stalls++;
        if (e_alloc) m_issued++;
        if (rb) begin
          mq.delete();
          mst = M_FLUSH;
        end else begin
          if (do_pop) void'(mq.pop_front());
          if (e_ready && fv) mq.push_back('{instr: ins, pc: p});
          if (mst == M_FLUSH) mst = M_RUN;
          else mst = blk ? M_STALL : M_RUN;
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
